// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and byte-lane helpers for the unified RAM port controller.
package mem_ctrl_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] IF_BYTES = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Encodings 2 and 3 are both full-word accesses.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the fetch unit, the MEM stage, the RAM and mem_ctrl.
interface mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_flush;
  logic                  if_done;
  logic [31:0]           if_inst;

  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_size;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_done;
  logic [31:0]           mem_rdata;

  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;
  logic [7:0]            ram_dout;
  logic [7:0]            ram_din;

  modport slave (
    input  if_req, if_addr, if_flush,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  ram_din,
    output if_done, if_inst,
    output mem_done, mem_rdata,
    output ram_a, ram_wr, ram_dout
  );

  modport master (
    output if_req, if_addr, if_flush,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output ram_din,
    input  if_done, if_inst,
    input  mem_done, mem_rdata,
    input  ram_a, ram_wr, ram_dout
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial arbiter for the unified RAM port: the MEM stage beats instruction fetch, and each
// access is split into byte cycles and returned little-endian with a one-cycle done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  state_e                state_r;
  owner_e                owner_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [31:0]           wdata_r;
  logic [2:0]            nbytes_r;
  logic [2:0]            cnt_r;
  logic [31:0]           data_r;
  logic [ADDR_WIDTH-1:0] ram_a_r;
  logic                  ram_wr_r;
  logic [7:0]            ram_dout_r;
  logic                  if_done_r;
  logic                  mem_done_r;
  logic [31:0]           if_inst_r;
  logic [31:0]           mem_rdata_r;

  logic [2:0]            cnt_nxt_s;
  logic                  more_s;
  logic [1:0]            cap_idx_s;
  logic [31:0]           data_cap_s;
  logic [ADDR_WIDTH-1:0] next_a_s;
  logic                  if_abort_s;

  // Next-byte bookkeeping shared by the read and write sequencers
  always_comb begin
    cnt_nxt_s  = cnt_r + 3'd1;
    more_s     = (cnt_nxt_s < nbytes_r);
    // ram_din lags ram_a by one cycle, so the byte arriving now belongs to lane cnt_r-1.
    cap_idx_s  = cnt_r[1:0] - 2'd1;
    data_cap_s = put_byte(data_r, cap_idx_s, bus.ram_din);
    next_a_s   = addr_r + ADDR_WIDTH'(cnt_nxt_s);
    if_abort_s = (owner_r == OWN_IF) && bus.if_flush;
  end

  // Arbitration, byte sequencing and registered RAM/requester outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_IF;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= 32'h0000_0000;
      nbytes_r    <= 3'd0;
      cnt_r       <= 3'd0;
      data_r      <= 32'h0000_0000;
      ram_a_r     <= {ADDR_WIDTH{1'b0}};
      ram_wr_r    <= 1'b0;
      ram_dout_r  <= 8'h00;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_inst_r   <= 32'h0000_0000;
      mem_rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r  <= 3'd0;
          data_r <= 32'h0000_0000;
          if (bus.mem_req) begin
            owner_r  <= OWN_MEM;
            addr_r   <= bus.mem_addr;
            wdata_r  <= bus.mem_wdata;
            nbytes_r <= size_bytes(bus.mem_size);
            ram_a_r  <= bus.mem_addr;
            if (bus.mem_we) begin
              ram_wr_r   <= 1'b1;
              ram_dout_r <= bus.mem_wdata[7:0];
              state_r    <= ST_WRITE;
            end else begin
              state_r    <= ST_READ;
            end
          end else if (bus.if_req && !bus.if_flush) begin
            owner_r  <= OWN_IF;
            addr_r   <= bus.if_addr;
            wdata_r  <= 32'h0000_0000;
            nbytes_r <= IF_BYTES;
            ram_a_r  <= bus.if_addr;
            state_r  <= ST_READ;
          end else begin
            state_r  <= ST_IDLE;
          end
        end

        ST_READ: begin
          if (if_abort_s) begin
            ram_a_r <= {ADDR_WIDTH{1'b0}};
            cnt_r   <= 3'd0;
            state_r <= ST_IDLE;
          end else begin
            if (cnt_r != 3'd0) begin
              data_r <= data_cap_s;
            end
            ram_a_r <= more_s ? next_a_s : {ADDR_WIDTH{1'b0}};
            if (cnt_r == nbytes_r) begin
              cnt_r   <= 3'd0;
              state_r <= ST_DONE;
              if (owner_r == OWN_MEM) begin
                mem_done_r  <= 1'b1;
                mem_rdata_r <= data_cap_s;
              end else begin
                if_done_r   <= 1'b1;
                if_inst_r   <= data_cap_s;
              end
            end else begin
              cnt_r <= cnt_nxt_s;
            end
          end
        end

        ST_WRITE: begin
          if (more_s) begin
            ram_a_r    <= next_a_s;
            ram_dout_r <= get_byte(wdata_r, cnt_nxt_s[1:0]);
            cnt_r      <= cnt_nxt_s;
          end else begin
            ram_a_r    <= {ADDR_WIDTH{1'b0}};
            ram_wr_r   <= 1'b0;
            ram_dout_r <= 8'h00;
            cnt_r      <= 3'd0;
            mem_done_r <= 1'b1;
            state_r    <= ST_DONE;
          end
        end

        ST_DONE: begin
          if_done_r  <= 1'b0;
          mem_done_r <= 1'b0;
          state_r    <= ST_IDLE;
        end

        default: begin
          ram_a_r    <= {ADDR_WIDTH{1'b0}};
          ram_wr_r   <= 1'b0;
          if_done_r  <= 1'b0;
          mem_done_r <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  // A redirect arriving during the IF done cycle must still kill the stale instruction.
  assign bus.if_done   = if_done_r & ~bus.if_flush;
  assign bus.if_inst   = if_inst_r;
  assign bus.mem_done  = mem_done_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign bus.ram_a     = ram_a_r;
  assign bus.ram_wr    = ram_wr_r;
  assign bus.ram_dout  = ram_dout_r;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide synchronous RAM model plus cycle-exact checks.
module tb_mem_ctrl;

  localparam int AW = 32;

  logic clk;
  logic rst;

  mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] init_mem [0:65535];
  logic [7:0] wr_mem   [0:65535];
  bit         wr_flag  [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    return wr_flag[a] ? wr_mem[a] : init_mem[a];
  endfunction

  // Synchronous RAM: read data valid one cycle after ram_a, writes commit at the edge
  always @(posedge clk) begin
    bus.ram_din <= mem_rd(bus.ram_a[15:0]);
    if (bus.ram_wr) begin
      wr_mem[bus.ram_a[15:0]]  <= bus.ram_dout;
      wr_flag[bus.ram_a[15:0]] <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 32'h0;
    bus.if_flush  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_size  = 2'd0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_a"},     bus.ram_a,     32'h0);
    check({tag, "_ram_wr"},    {31'd0, bus.ram_wr},   32'h0);
    check({tag, "_ram_dout"},  {24'd0, bus.ram_dout}, 32'h0);
    check({tag, "_if_done"},   {31'd0, bus.if_done},  32'h0);
    check({tag, "_mem_done"},  {31'd0, bus.mem_done}, 32'h0);
    check({tag, "_if_inst"},   bus.if_inst,   32'h0);
    check({tag, "_mem_rdata"}, bus.mem_rdata, 32'h0);
  endtask

  // One MEM access: mem_done must appear exactly lat cycles after the acceptance edge
  task automatic run_mem(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, input logic [31:0] exp_rdata);
    int seen;
    seen = 0;
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_size  = size;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    for (int c = 1; c <= lat + 4 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.mem_done) seen = c;
    end
    check({tag, "_latency"}, 32'(seen), 32'(lat));
    if (!we) check({tag, "_rdata"}, bus.mem_rdata, exp_rdata);
    bus.mem_req = 1'b0;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, bus.mem_done}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int if_pulses;

    idle_inputs();
    rst = 1'b0;
    init_mem[16'h0000] = 8'h00;
    init_mem[16'h0100] = 8'h13; init_mem[16'h0101] = 8'h05;
    init_mem[16'h0102] = 8'h00; init_mem[16'h0103] = 8'h00;
    init_mem[16'h0200] = 8'hAA; init_mem[16'h0201] = 8'hBB;
    init_mem[16'h0202] = 8'hCC; init_mem[16'h0203] = 8'hDD;
    init_mem[16'h0300] = 8'h00; init_mem[16'h0301] = 8'h00;
    init_mem[16'h0302] = 8'h00; init_mem[16'h0303] = 8'h00;
    init_mem[16'h2000] = 8'h11; init_mem[16'h2001] = 8'h22;
    init_mem[16'h2002] = 8'h33; init_mem[16'h2003] = 8'h5A;
    init_mem[16'h0030] = 8'h80; init_mem[16'h0031] = 8'hFF;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // IF word fetch of 0x100: address per cycle t+1..t+4, if_done in t+6
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 4) check("if_ram_a", bus.ram_a, 32'h100 + 32'(k) - 32'd1);
      check("if_ram_wr", {31'd0, bus.ram_wr}, 32'h0);
      check("if_done_cycle", {31'd0, bus.if_done}, (k == 6) ? 32'd1 : 32'd0);
    end
    check("if_inst", bus.if_inst, 32'h0000_0513);
    bus.if_req = 1'b0;
    @(negedge clk);
    check("if_done_one_cycle", {31'd0, bus.if_done}, 32'h0);
    check("if_inst_hold", bus.if_inst, 32'h0000_0513);

    // Half store of 0xDEADBEEF at 0x2001
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_size  = 2'd1;
    bus.mem_addr  = 32'h2001;
    bus.mem_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("st_a0", bus.ram_a, 32'h2001);
    check("st_wr0", {31'd0, bus.ram_wr}, 32'h1);
    check("st_d0", {24'd0, bus.ram_dout}, 32'hEF);
    @(negedge clk);
    check("st_a1", bus.ram_a, 32'h2002);
    check("st_wr1", {31'd0, bus.ram_wr}, 32'h1);
    check("st_d1", {24'd0, bus.ram_dout}, 32'hBE);
    check("st_early_done", {31'd0, bus.mem_done}, 32'h0);
    @(negedge clk);
    check("st_done", {31'd0, bus.mem_done}, 32'h1);
    check("st_wr_off", {31'd0, bus.ram_wr}, 32'h0);
    check("st_a_idle", bus.ram_a, 32'h0);
    bus.mem_req = 1'b0;
    @(negedge clk);
    check("st_ram_2001", {24'd0, mem_rd(16'h2001)}, 32'hEF);
    check("st_ram_2002", {24'd0, mem_rd(16'h2002)}, 32'hBE);

    run_mem("ld_b_2003", 1'b0, 2'd0, 32'h2003, 32'h0, 3, 32'h0000_005A);
    run_mem("ld_b_30",   1'b0, 2'd0, 32'h0030, 32'h0, 3, 32'h0000_0080);
    run_mem("ld_h_2001", 1'b0, 2'd1, 32'h2001, 32'h0, 4, 32'h0000_BEEF);

    // Simultaneous requests: MEM word load first, IF accepted at the IDLE edge after DONE
    bus.if_addr  = 32'h100;
    bus.if_req   = 1'b1;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_size = 2'd2;
    bus.mem_addr = 32'h2000;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) check("arb_mem_first", bus.ram_a, 32'h2000);
      check("arb_no_if_done", {31'd0, bus.if_done}, 32'h0);
    end
    check("arb_mem_done", {31'd0, bus.mem_done}, 32'h1);
    check("arb_mem_rdata", bus.mem_rdata, 32'h5ABE_EF11);
    bus.mem_req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 15 && seen == 0; c++) begin
      @(negedge clk);
      if (c == 2) check("arb_if_addr", bus.ram_a, 32'h100);
      if (bus.if_done) seen = c;
    end
    check("arb_if_latency", 32'(seen), 32'd7);
    check("arb_if_inst", bus.if_inst, 32'h0000_0513);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Flush raised during the IF done cycle suppresses if_done
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    repeat (6) @(negedge clk);
    bus.if_flush = 1'b1;
    #1;
    check("flush_done_suppressed", {31'd0, bus.if_done}, 32'h0);
    bus.if_req = 1'b0;
    @(negedge clk);
    bus.if_flush = 1'b0;
    @(negedge clk);

    // Flush in cycle t+3 of an IF read with a MEM byte load waiting
    bus.if_addr = 32'h200;
    bus.if_req  = 1'b1;
    if_pulses   = 0;
    repeat (3) @(negedge clk);
    check("flush_mid_addr", bus.ram_a, 32'h202);
    bus.if_flush = 1'b1;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_size = 2'd0;
    bus.mem_addr = 32'h30;
    @(negedge clk);
    check("flush_idle_addr", bus.ram_a, 32'h0);
    bus.if_flush = 1'b0;
    bus.if_req   = 1'b0;
    @(negedge clk);
    check("flush_mem_accept", bus.ram_a, 32'h30);
    seen = 0;
    for (int c = 1; c <= 8 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.if_done) if_pulses++;
      if (bus.mem_done) seen = c;
    end
    check("flush_mem_latency", 32'(seen), 32'd2);
    check("flush_mem_rdata", bus.mem_rdata, 32'h0000_0080);
    check("flush_no_if_done", 32'(if_pulses), 32'd0);
    check("flush_if_inst_hold", bus.if_inst, 32'h0000_0513);
    bus.mem_req = 1'b0;
    @(negedge clk);

    // Word store of 0x44332211 at 0x300, reset right after byte 1 commits
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_size  = 2'd2;
    bus.mem_addr  = 32'h300;
    bus.mem_wdata = 32'h4433_2211;
    @(negedge clk);
    check("rst_wr_a0", bus.ram_a, 32'h300);
    @(negedge clk);
    check("rst_wr_a1", bus.ram_a, 32'h301);
    check("rst_wr_d1", {24'd0, bus.ram_dout}, 32'h22);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("rst_async");
    bus.mem_req = 1'b0;
    seen = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (bus.mem_done || bus.ram_wr) seen++;
    end
    check("rst_no_activity", 32'(seen), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ram_300", {24'd0, mem_rd(16'h0300)}, 32'h11);
    check("rst_ram_301", {24'd0, mem_rd(16'h0301)}, 32'h22);
    check("rst_ram_302", {24'd0, mem_rd(16'h0302)}, 32'h00);
    check("rst_ram_303", {24'd0, mem_rd(16'h0303)}, 32'h00);
    check("rst_post_done", {31'd0, bus.mem_done}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the single byte-wide unified RAM port between instruction fetch (IF) and the MEM stage.
- Splits each 1/2/4-byte access into a sequence of byte cycles, then returns assembled little-endian data with a one-cycle done pulse.
- Requesters stall the pipeline (via the stall controller) while their request is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of request and RAM addresses.

Ports:
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request, held until if_done
- if_addr  in  ADDR_WIDTH  IF word address
- if_flush  in  1  abort pending/in-progress IF access (branch redirect)
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched instruction
- mem_req  in  1  MEM-stage request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  0 byte, 1 half, 2/3 word
- mem_addr  in  ADDR_WIDTH  byte address
- mem_wdata  in  32  store data, byte k = bits [8k+7:8k]
- mem_done  out  1  one-cycle pulse, access complete
- mem_rdata  out  32  load data, zero-extended raw bytes
- ram_a  out  ADDR_WIDTH  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write data
- ram_din  in  8  RAM read data, valid one cycle after ram_a

Behaviour:
- Reset (rst low, any time, including mid-transaction):
  - State goes to IDLE.
  - All outputs and internal data/count registers go to 0.
  - Partial data is discarded and no done pulse is issued.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE arbitration, sampled at the posedge:
  - mem_req has priority over if_req.
  - if_req is ignored while if_flush is high.
  - Winner's address, size, we and wdata are latched.
  - Next state is WRITE for a store, READ otherwise.
  - IF requests are always N = 4 bytes.
- Non-preemptive: once accepted, a MEM access always completes.
- Cycle numbering: acceptance edge = edge t.
- READ:
  - Byte k address (base + k, modulo 2^ADDR_WIDTH) is driven on ram_a in cycle t+1+k, k = 0..N-1.
  - ram_din is captured into bits [8k+7:8k] at the end of cycle t+2+k.
  - After the last capture the FSM enters DONE.
  - Total: done high in cycle t+2+N (word read: done 6 cycles after acceptance).
- WRITE:
  - Cycle t+1+k drives ram_a = base + k, ram_wr = 1, ram_dout = wdata byte k.
  - Then DONE; done is high in cycle t+1+N.
- ram_wr is 1 only in WRITE cycles; otherwise 0 and ram_a = 0.
- DONE:
  - Exactly one cycle; the owner's done output is high and its data output is stable.
  - Returns to IDLE; no request is accepted on the DONE→IDLE edge.
  - if_inst and mem_rdata hold their value until the next completion of the same requester.
- Requester contract: each requester clears its req at the edge where it samples done high, so req is low in the following IDLE cycle.
- Unused upper bytes of mem_rdata: byte → [31:8] = 0; half → [31:16] = 0.
- Sign extension is performed by the MEM stage, not here.
- if_flush:
  - During an IF READ: abandon it, go to IDLE on the next edge, no if_done.
  - In DONE owned by IF: if_done is suppressed.
  - No effect on MEM transactions.
- Simultaneous mem_req and if_req in IDLE: MEM served first. IF is served in the next IDLE cycle if still requested.
- Misaligned addresses: no checking; bytes are simply issued sequentially.

Decomposition:
- Shared package/config header:
  - size encodings (SIZE_BYTE/HALF/WORD)
  - FSM state encodings
  - owner encoding (OWN_IF/OWN_MEM)
- No sub-module needed.
- An optional byte-lane assembler (mem_byte_pack) is natural if the store/load lane logic is reused by an I/O bridge; otherwise keep it inline.

Test Plan:
- IF only:
  - Stimulus: if_addr = 0x100, RAM[0x100..0x103] = 13 05 00 00.
  - Required: ram_a = 0x100..0x103 in cycles t+1..t+4; if_done in cycle t+6; if_inst = 0x00000513.
- MEM store half:
  - Stimulus: addr = 0x2001, wdata = 0xDEADBEEF, size = 1.
  - Required: ram_wr = 1 with ram_dout EF then BE at 0x2001/0x2002; mem_done in cycle t+3; subsequent byte read of 0x2003 unchanged.
- MEM load byte:
  - Stimulus: RAM[0x30] = 0x80.
  - Required: mem_rdata = 0x00000080; mem_done in cycle t+3.
- Arbitration:
  - Stimulus: if_req and mem_req (load word) rise together.
  - Required: MEM is served first; IF is accepted at the first IDLE edge after DONE; if_done arrives 6 cycles after that.
- Flush:
  - Stimulus: if_flush in cycle t+3 of an IF read.
  - Required: no if_done; FSM in IDLE next cycle; a pending mem_req is accepted at the following edge.
- Reset mid-write:
  - Stimulus: rst low in cycle t+2 of a word store.
  - Required: ram_wr and all outputs 0 immediately (asynchronous), no mem_done, and only bytes 0–1 written.
